// File: rtl/rf_scoreboard.sv
// rf_scoreboard: in-order register-write scoreboard that raises a decode read-stall
// when a source register's youngest in-flight writer has not produced its data yet
module rf_scoreboard #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   issue_fire,
   input  logic                   issue_we,
   input  logic [4:0]             issue_waddr,
   input  logic                   issue_long,
   input  logic                   ready_fire,
   input  logic                   wb_fire,
   input  logic                   flush,
   input  logic [4:0]             raddr1,
   input  logic [4:0]             raddr2,
   output logic                   stall,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
   logic [DEPTH-1:0] valid, we_q, pend;
   logic [4:0]       waddr_q [DEPTH];
   logic [AW-1:0]    head, tail, idx, rdy_idx;
   logic             rdy_hit, s1, s2, push, pop;
   assign full  = count == DEP;
   assign pop   = wb_fire && count != '0;
   assign push  = issue_fire && (!full || pop);
   assign stall = s1 || s2;
   // walk oldest to youngest so the last match is the youngest writer
   always_comb begin
      s1 = 1'b0;
      s2 = 1'b0;
      rdy_hit = 1'b0;
      rdy_idx = '0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (valid[idx] && we_q[idx] && waddr_q[idx] != 5'd0) begin
            s1 = waddr_q[idx] == raddr1 ? pend[idx] : s1;
            s2 = waddr_q[idx] == raddr2 ? pend[idx] : s2;
         end
         if (!rdy_hit && valid[idx] && pend[idx]) begin
            rdy_hit = 1'b1;
            rdy_idx = idx;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid     <= '0;
         pend      <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         valid <= '0;
         pend  <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (ready_fire && rdy_hit)
            pend[rdy_idx] <= 1'b0;
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + AW'(1);
         end
         // push last: when full with a pop, tail aliases the freed head slot
         if (push) begin
            valid[tail]   <= 1'b1;
            we_q[tail]    <= issue_we;
            waddr_q[tail] <= issue_waddr;
            pend[tail]    <= issue_we && issue_long;
            tail          <= tail + AW'(1);
         end
         count     <= count + (AW+1)'(push) - (AW+1)'(pop);
         overflow  <= overflow || (issue_fire && full && !wb_fire);
         underflow <= underflow || (wb_fire && count == '0);
      end
   end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

In-order register-write scoreboard that feeds the decode-stage hazard logic from the producer side. Every instruction leaving ID is recorded with its destination register and whether its result is still pending (load/mul/div). Entries retire at writeback. The block raises a read-stall when a source register's youngest in-flight writer has not produced its data yet.

## Interface
- DEPTH, 4, in-flight entries (EXE/MEM/WB plus one slack); power of two, ≥2
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- issue_fire  in  1  instruction moves ID→EXE this cycle
- issue_we  in  1  instruction writes the register file
- issue_waddr  in  5  destination register
- issue_long  in  1  result not available until a later ready_fire (load/mul/div)
- ready_fire  in  1  oldest pending long result has become forwardable
- wb_fire  in  1  oldest instruction retires in WB
- flush  in  1  exception/ertn flush; discards all entries
- raddr1, raddr2  in  5  decode-stage source registers
- stall  out  1  some source register's youngest writer is pending
- full  out  1  occupancy == DEPTH
- count  out  $clog2(DEPTH)+1  occupancy
- overflow, underflow  out  1  sticky protocol-error flags

## Operation
- Storage: circular FIFO of DEPTH entries {valid, we, waddr, pending}, head/tail pointers, occupancy counter.
- Issue: when issue_fire, push {1, issue_we, issue_waddr, issue_we && issue_long} at tail. Push happens for every instruction, including we=0, so WB pops stay aligned.
- Ready: when ready_fire, clear pending on the oldest entry with pending=1. Long results complete in program order. If no entry is pending, ignore the event.
- Retire: when wb_fire, pop head. The popped entry's pending bit is irrelevant.
- Stall (combinational from registered state only; same-cycle issue/ready/wb do not affect it):
  - For each nonzero raddr, select the youngest valid entry with we=1 and waddr==raddr.
  - stall = selected entry for raddr1 is pending OR selected entry for raddr2 is pending.
  - raddr==0 never stalls. Entries with waddr==0 never match.
  - An older pending writer does not stall when a younger non-pending writer to the same register exists.
- Errors:
  - issue_fire while full and no wb_fire: push dropped, overflow←1.
  - wb_fire while count==0: ignored, underflow←1.
  - Both flags are sticky until reset.
- Flush: all valid and pending bits cleared, pointers and count return to 0. Flush overrides same-cycle issue/ready/wb. The error flags are kept.

## Timing
- Reset (resetn=0 at a clk edge): count=0, full=0, stall=0, overflow=0, underflow=0, all entries invalid, head=tail=0.
- All state updates on the rising clk edge. stall, full and count reflect state after the last edge (0-cycle combinational read, 1-cycle update latency).
- Same-cycle events:
  - issue+wb: count unchanged. Push is legal even when full.
  - ready+wb: ready applies to the oldest pending entry among pre-pop state. If that is the head, the head is popped anyway.
  - issue+ready: ready never targets the entry being pushed.
- Pointers wrap modulo DEPTH. count saturates nowhere; it is protected by the drop rule.
- Reset mid-operation: identical to the power-on reset values above.

## Test plan
- Load-use:
  - Stimulus: issue {we=1, waddr=5, long=1}, then raddr1=5.
  - Required: stall=1 next cycle. After ready_fire, stall=0 the following cycle. wb_fire → count 1→0.
- Younger short writer masks older long:
  - Stimulus: issue r7 long, then issue r7 short, raddr2=7.
  - Required: stall=0.
  - Then issue r7 long again. Required: stall=1.
- r0 and we=0:
  - Stimulus: issue {we=1, waddr=0, long=1} and {we=0, waddr=3, long=1}; raddr1=0, raddr2=3.
  - Required: stall=0 throughout. count=2.
- Full and overflow:
  - Stimulus: four issues. Required: full=1, count=4.
  - Fifth issue without wb_fire. Required: count stays 4, overflow=1.
  - Issue+wb in the same cycle. Required: count=4, overflow still 1.
- Flush and underflow:
  - Stimulus: three entries with pending r9, raddr1=9, then flush.
  - Required: stall=0, count=0 next cycle.
  - Then wb_fire. Required: underflow=1, count stays 0.
- Reset mid-stream:
  - Stimulus: resetn=0 for 1 cycle with 3 pending entries.
  - Required: all outputs 0 next cycle.
